ml_vector_mac_unit: RTL and testbench
=====================================

Name: ml_vector_mac_unit

Overview:
Parametrised successor to the dummy NPU core. It is a LANES-wide SIMD engine that runs one ML operation per start.
- MAC / MAC_RELU: accumulate K weight×activation pairs per lane, then emit one requantised result beat.
- RELU: element-wise ReLU streaming, K beats in and K beats out.
- Sits between the DMA read stream and the DMA write stream. It is controlled by the CPU register block through start/done/error.

Parameters:
LANES, 16, number of parallel lanes.
ELEM_W, 8, signed element width, for both input and output.
ACC_W, 32, signed per-lane accumulator width; must be ≥ 2*ELEM_W.
CNT_W, 16, width of the beat/pair counter.
Derived localparam DATA_WIDTH = LANES*ELEM_W. Lane i occupies bits [i*ELEM_W +: ELEM_W].

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
start  in  1  start pulse; sampled only in IDLE
done  out  1  one-cycle pulse when the operation completes
error  out  1  one-cycle pulse when a command is rejected
busy  out  1  high whenever state != IDLE
op_code  in  32  0=MAC, 1=MAC_RELU, 2=RELU; any other value is illegal
op_params_0  in  32  [CNT_W-1:0] = K (pairs for MAC modes, beats for RELU)
op_params_1  in  32  [4:0] = arithmetic right shift applied before saturation (MAC modes only)
s_axis_data_tdata  in  DATA_WIDTH  input beat
s_axis_data_tvalid  in  1  input valid
s_axis_data_tready  out  1  input ready
m_axis_result_tdata  out  DATA_WIDTH  result beat
m_axis_result_tvalid  out  1  result valid
m_axis_result_tready  in  1  result ready
m_axis_result_tlast  out  1  marks the final result beat of the operation

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulators, counters, phase bit and latched command cleared.
- States: IDLE, LOAD, DRAIN, FINISH.
- IDLE:
  - On start, latch op_code, K and shift.
  - If op_code > 2 or K == 0: pulse error the next cycle and stay in IDLE.
  - Otherwise clear the accumulators, clear the phase bit and go to LOAD.
  - start is ignored in every other state.
- LOAD, MAC / MAC_RELU:
  - s_tready = 1.
  - Beats alternate: phase 0 = weight beat (register it), phase 1 = activation beat.
  - On an activation handshake, acc[i] += sext(w[i]*a[i]). Accumulation wraps modulo 2^ACC_W with no saturation.
  - Increment the pair count on each activation handshake. When the K-th pair's activation is accepted, go to DRAIN.
  - m_tvalid = 0 in LOAD.
- DRAIN, MAC modes:
  - m_tvalid = 1, starting the cycle after the final activation handshake.
  - Lane output = sat_ELEM_W(acc[i] >>> shift), saturating to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1].
  - MAC_RELU additionally clamps negative results to 0.
  - tlast = 1. tdata is held stable while tvalid && !tready.
  - On handshake, go to FINISH.
- LOAD, RELU:
  - Single output register. s_tready = !m_tvalid || m_tready.
  - Each accepted beat loads relu(lane) per lane; latency 1 cycle from input handshake to tvalid.
  - Input and output handshakes in the same cycle sustain 1 beat/cycle.
  - tlast is set on the K-th loaded beat.
  - After the K-th output handshake, go to FINISH; no further input is accepted once K beats are in.
- FINISH: pulse done for 1 cycle, go to IDLE.
- Backpressure: tready = 0 in any mode stalls without data loss or duplication.
- Deasserting rst_n mid-operation aborts immediately: outputs 0, state IDLE, no done pulse.
- s_tready = 0 in IDLE, DRAIN and FINISH.

Decomposition:
- Package ml_pu_pkg: op_code constants (OP_MAC=0, OP_MAC_RELU=1, OP_RELU=2), state enum encoding, sat/relu helper functions. Shared with ml_processing_unit's successors.
- One sub-module, ml_mac_lane: one lane's multiply, accumulate, clear, shift, saturate and ReLU. Instantiated LANES times via generate.

Test Plan:
1. MAC, K=3, shift=0, all lanes w=2, a=3 → one beat, every lane 18, tlast=1; done pulses one cycle after the handshake.
2. MAC, K=4, w=127, a=127, shift=4 → acc 64516 >>> 4 = 4032 → saturates to 127. With w=-128, a=127 → -128.
3. MAC_RELU, K=1, lane0 w=-5 a=3, lane1 w=5 a=3 → lane0 0, lane1 15.
4. RELU, K=5, inputs {-1, 7, -128, 0, 127}, m_tready toggled 1-0-1 → outputs {0, 7, 0, 0, 127} in order, tlast on the 5th, no drops or duplicates.
5. start with op_code=7, or with K=0 → error pulse one cycle, busy stays 0, no tready.
6. rst_n low during LOAD of a K=10 MAC after 4 pairs, then a fresh K=1 w=1 a=1 run → result 1 (accumulators cleared), no spurious done.

Source files
------------

// File: rtl/ml_pu_pkg.sv
// Shared definitions for the ML processing-unit family: op codes, FSM state
// encoding and the saturate / ReLU arithmetic helpers.
// Ports: none (package only).
package ml_pu_pkg;

  // Operation codes as seen on the op_code register.
  localparam int OP_W = 2;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t         OP_MAC      = 2'd0;
  localparam op_t         OP_MAC_RELU = 2'd1;
  localparam op_t         OP_RELU     = 2'd2;
  // Highest legal value of the full 32-bit op_code field.
  localparam logic [31:0] OP_MAX      = 32'd2;

  // Controller state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOAD   = 2'd1;
  localparam state_t ST_DRAIN  = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

  // Saturate a signed value to a w-bit signed range. Works on a 64-bit
  // carrier so callers of any width up to 64 bits can share it; callers
  // size-cast the result back down to w bits.
  function automatic logic signed [63:0] sat_s64(input logic signed [63:0] x,
                                                 input int unsigned        w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

  // Clamp negative values to zero.
  function automatic logic signed [63:0] relu_s64(input logic signed [63:0] x);
    return (x < 0) ? 64'sd0 : x;
  endfunction

endpackage

// File: rtl/ml_mac_lane.sv
// One SIMD lane: weight register, signed multiply-accumulate, and the
// shift / saturate / optional ReLU output stage, plus a pass-through ReLU of
// the raw input element for the streaming mode.
// Ports: clk/rst_n; clr_i, w_ld_i, mac_en_i control strobes; relu_mode_i and
// shift_i shape the MAC result; x_i input element; mac_o, relu_o results.
module ml_mac_lane
  import ml_pu_pkg::*;
#(
  parameter int ELEM_W = 8,
  parameter int ACC_W  = 32   // must be >= 2*ELEM_W and <= 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     w_ld_i,
  input  logic                     mac_en_i,
  input  logic                     relu_mode_i,
  input  logic [4:0]               shift_i,
  input  logic signed [ELEM_W-1:0] x_i,
  output logic [ELEM_W-1:0]        mac_o,
  output logic [ELEM_W-1:0]        relu_o
);

  logic signed [ELEM_W-1:0]   w_q;
  logic signed [ELEM_W-1:0]   w_d;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [2*ELEM_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_sh;
  logic signed [63:0]         sat_val;

  // Full-precision signed product; the ACC_W cast sign-extends it, and the
  // accumulator is allowed to wrap.
  assign prod = w_q * x_i;

  always_comb begin
    w_d   = w_q;
    acc_d = acc_q;
    if (w_ld_i) begin
      w_d = x_i;
    end
    if (clr_i) begin
      acc_d = '0;
    end else if (mac_en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q   <= '0;
      acc_q <= '0;
    end else begin
      w_q   <= w_d;
      acc_q <= acc_d;
    end
  end

  assign acc_sh  = acc_q >>> shift_i;
  assign sat_val = sat_s64(64'(acc_sh), ELEM_W);

  assign mac_o  = relu_mode_i ? ELEM_W'(relu_s64(sat_val)) : ELEM_W'(sat_val);
  assign relu_o = ELEM_W'(relu_s64(64'(x_i)));

endmodule

// File: rtl/ml_vector_mac_unit.sv
// LANES-wide SIMD engine running one ML op per start: MAC / MAC_RELU reduce K
// weight/activation beat pairs to one requantised beat; RELU streams K beats.
// Ports: clk/rst_n; start/op_code/op_params_* command with done/error/busy
// status; s_axis_data_* input stream; m_axis_result_* output stream.
module ml_vector_mac_unit
  import ml_pu_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int ELEM_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16,
  localparam int DATA_WIDTH = LANES * ELEM_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  done,
  output logic                  error,
  output logic                  busy,
  input  logic [31:0]           op_code,
  input  logic [31:0]           op_params_0,
  input  logic [31:0]           op_params_1,
  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  output logic [DATA_WIDTH-1:0] m_axis_result_tdata,
  output logic                  m_axis_result_tvalid,
  input  logic                  m_axis_result_tready,
  output logic                  m_axis_result_tlast
);

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [CNT_W-1:0]      k_q, k_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4:0]            shift_q, shift_d;
  logic                  phase_q, phase_d;   // 0: expecting weight, 1: activation
  logic                  err_q, err_d;
  logic                  r_vld_q, r_vld_d;   // RELU output register
  logic                  r_last_q, r_last_d;
  logic [DATA_WIDTH-1:0] r_dat_q, r_dat_d;

  logic                  lane_clr;
  logic                  lane_w_ld;
  logic                  lane_mac_en;
  logic                  s_rdy;
  logic                  in_hs;
  logic                  out_hs;
  logic                  is_relu;
  logic                  cmd_bad;
  logic                  cnt_last;
  logic [DATA_WIDTH-1:0] mac_vec;
  logic [DATA_WIDTH-1:0] relu_vec;

  // Upper command bits carry no meaning for this unit.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{op_params_0[31:CNT_W], op_params_1[31:5]};

  assign is_relu  = (op_q == OP_RELU);
  assign cmd_bad  = (op_code > OP_MAX) || (op_params_0[CNT_W-1:0] == '0);
  // True when the beat/pair currently being accepted is the K-th one.
  assign cnt_last = ((cnt_q + CNT_W'(1)) == k_q);

  assign in_hs  = s_axis_data_tvalid && s_rdy;
  assign out_hs = m_axis_result_tvalid && m_axis_result_tready;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    phase_d     = phase_q;
    err_d       = 1'b0;
    r_vld_d     = r_vld_q;
    r_last_d    = r_last_q;
    r_dat_d     = r_dat_q;
    lane_clr    = 1'b0;
    lane_w_ld   = 1'b0;
    lane_mac_en = 1'b0;
    s_rdy       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op_code[OP_W-1:0];
          k_d     = op_params_0[CNT_W-1:0];
          shift_d = op_params_1[4:0];
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            lane_clr = 1'b1;
            phase_d  = 1'b0;
            cnt_d    = '0;
            r_vld_d  = 1'b0;
            r_last_d = 1'b0;
            state_d  = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (is_relu) begin
          // Single output register: accept a new beat when it is empty or
          // draining this cycle, and stop once all K beats have come in.
          s_rdy = (cnt_q != k_q) && (!r_vld_q || m_axis_result_tready);
          if (out_hs) begin
            r_vld_d = 1'b0;
            if (r_last_q) begin
              state_d = ST_FINISH;
            end
          end
          if (in_hs) begin
            r_dat_d  = relu_vec;
            r_vld_d  = 1'b1;
            r_last_d = cnt_last;
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end else begin
          s_rdy = 1'b1;
          if (in_hs) begin
            if (!phase_q) begin
              lane_w_ld = 1'b1;
              phase_d   = 1'b1;
            end else begin
              lane_mac_en = 1'b1;
              phase_d     = 1'b0;
              cnt_d       = cnt_q + CNT_W'(1);
              if (cnt_last) begin
                state_d = ST_DRAIN;
              end
            end
          end
        end
      end

      ST_DRAIN: begin
        if (m_axis_result_tready) begin
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      phase_q  <= 1'b0;
      err_q    <= 1'b0;
      r_vld_q  <= 1'b0;
      r_last_q <= 1'b0;
      r_dat_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      phase_q  <= phase_d;
      err_q    <= err_d;
      r_vld_q  <= r_vld_d;
      r_last_q <= r_last_d;
      r_dat_q  <= r_dat_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ml_mac_lane #(
      .ELEM_W (ELEM_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (lane_clr),
      .w_ld_i      (lane_w_ld),
      .mac_en_i    (lane_mac_en),
      .relu_mode_i (op_q == OP_MAC_RELU),
      .shift_i     (shift_q),
      .x_i         (s_axis_data_tdata[i*ELEM_W +: ELEM_W]),
      .mac_o       (mac_vec[i*ELEM_W +: ELEM_W]),
      .relu_o      (relu_vec[i*ELEM_W +: ELEM_W])
    );
  end

  // In DRAIN the accumulators are frozen, so the combinational MAC result is
  // stable for as long as the sink stalls.
  assign m_axis_result_tdata  = (state_q == ST_DRAIN) ? mac_vec : r_dat_q;
  assign m_axis_result_tvalid = (state_q == ST_DRAIN) || r_vld_q;
  assign m_axis_result_tlast  = (state_q == ST_DRAIN) || (r_vld_q && r_last_q);
  assign s_axis_data_tready   = s_rdy;
  assign done                 = (state_q == ST_FINISH);
  assign busy                 = (state_q != ST_IDLE);
  assign error                = err_q;

endmodule

// File: tb/tb_ml_vector_mac_unit.sv
module tb_ml_vector_mac_unit;

  localparam int L  = 16;
  localparam int EW = 8;
  localparam int DW = L * EW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   op_code = '0;
  logic [31:0]   p0 = '0;
  logic [31:0]   p1 = '0;
  logic [DW-1:0] s_dat = '0;
  logic          s_vld = 1'b0;
  logic          s_rdy;
  logic [DW-1:0] m_dat;
  logic          m_vld;
  logic          m_rdy = 1'b1;
  logic          m_last;
  logic          done, error, busy;

  ml_vector_mac_unit dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .done                 (done),
    .error                (error),
    .busy                 (busy),
    .op_code              (op_code),
    .op_params_0          (p0),
    .op_params_1          (p1),
    .s_axis_data_tdata    (s_dat),
    .s_axis_data_tvalid   (s_vld),
    .s_axis_data_tready   (s_rdy),
    .m_axis_result_tdata  (m_dat),
    .m_axis_result_tvalid (m_vld),
    .m_axis_result_tready (m_rdy),
    .m_axis_result_tlast  (m_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            rdy_mode = 0;     // 0: always ready, 1: random, 2: toggle
  int            err_seen = 0;
  int            out_cnt = 0;
  logic [DW-1:0] last_out = '0;
  logic [DW-1:0] wv[64];
  logic [DW-1:0] av[64];
  logic [DW-1:0] rv[64];

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] bcast(input logic [7:0] v);
    return {L{v}};
  endfunction

  // Reference requantisation: arithmetic shift, clamp to int8, optional ReLU.
  function automatic logic [7:0] requant(input int acc, input int sh, input bit relu);
    int r;
    r = acc >>> sh;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    if (relu && r < 0) r = 0;
    return 8'(r);
  endfunction

  // Sink-ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_rdy = 1'b1;
        1:       m_rdy = 1'($urandom_range(0, 1));
        default: m_rdy = ~m_rdy;
      endcase
    end
  end

  // Per-cycle compare against the expected-beat queue and status rules.
  logic          prev_last_hs = 1'b0;
  logic          prev_stall = 1'b0;
  logic          prev_bad_start = 1'b0;
  logic [DW-1:0] prev_dat = '0;
  beat_t         e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_last_hs   = 1'b0;
      prev_stall     = 1'b0;
      prev_bad_start = 1'b0;
    end else begin
      check("done_pulse", DW'(done), DW'(prev_last_hs));
      check("error_pulse", DW'(error), DW'(prev_bad_start));
      if (error) err_seen++;
      if (prev_stall) begin
        check("stall_valid", DW'(m_vld), DW'(1));
        check("stall_data", m_dat, prev_dat);
      end
      if (m_vld && m_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", DW'(1), DW'(0));
        end else begin
          e = exp_q.pop_front();
          check("out_dat", m_dat, e.d);
          check("out_last", DW'(m_last), DW'(e.l));
        end
        last_out = m_dat;
        out_cnt++;
      end
      prev_last_hs   = m_vld && m_rdy && m_last;
      prev_stall     = m_vld && !m_rdy;
      prev_dat       = m_dat;
      prev_bad_start = start && ((op_code > 32'd2) || (p0[15:0] == 16'd0));
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic start_op(input int op, input int k, input int sh);
    check("idle_busy", DW'(busy), DW'(0));
    check("idle_tready", DW'(s_rdy), DW'(0));
    start   = 1'b1;
    op_code = 32'(op);
    p0      = 32'(k);
    p1      = 32'(sh);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d);
    int gap;
    int n;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_vld = 1'b1;
    s_dat = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_rdy) break;
      n++;
      if (n > 500) begin
        check("in_timeout", DW'(0), DW'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    s_vld = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      n++;
      if (n > 2000) begin
        check("done_timeout", DW'(0), DW'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    check("q_empty", DW'(exp_q.size()), DW'(0));
    check("busy_after", DW'(busy), DW'(0));
  endtask

  task automatic run_mac(input int op, input int k, input int sh);
    logic [DW-1:0] r;
    int acc;
    for (int l = 0; l < L; l++) begin
      acc = 0;
      for (int p = 0; p < k; p++)
        acc += int'($signed(wv[p][l*EW +: EW])) * int'($signed(av[p][l*EW +: EW]));
      r[l*EW +: EW] = requant(acc, sh, op == 1);
    end
    exp_q.push_back('{d: r, l: 1'b1});
    start_op(op, k, sh);
    for (int p = 0; p < k; p++) begin
      drive_beat(wv[p]);
      drive_beat(av[p]);
    end
    wait_done();
  endtask

  task automatic run_relu(input int k);
    logic [DW-1:0] r;
    for (int p = 0; p < k; p++) begin
      for (int l = 0; l < L; l++)
        r[l*EW +: EW] = rv[p][l*EW+EW-1] ? 8'd0 : rv[p][l*EW +: EW];
      exp_q.push_back('{d: r, l: (p == k - 1)});
    end
    start_op(2, k, 0);
    for (int p = 0; p < k; p++) drive_beat(rv[p]);
    wait_done();
  endtask

  int e0;
  int c0;
  int op;
  int k;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_error", DW'(error), DW'(0));
    check("rst_tvalid", DW'(m_vld), DW'(0));
    check("rst_tlast", DW'(m_last), DW'(0));
    check("rst_tdata", m_dat, DW'(0));
    check("rst_tready", DW'(s_rdy), DW'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: every lane 2*3 summed three times.
    for (int p = 0; p < 3; p++) begin wv[p] = bcast(8'd2); av[p] = bcast(8'd3); end
    run_mac(0, 3, 0);
    check("t1_result", last_out, {L{8'd18}});

    // 2: saturation high and low.
    for (int p = 0; p < 4; p++) begin wv[p] = bcast(8'd127); av[p] = bcast(8'd127); end
    run_mac(0, 4, 4);
    check("t2_sat_hi", last_out, {L{8'h7f}});
    for (int p = 0; p < 4; p++) wv[p] = bcast(8'h80);
    run_mac(0, 4, 4);
    check("t2_sat_lo", last_out, {L{8'h80}});

    // 3: MAC_RELU clamps the negative lane.
    wv[0] = '0;
    wv[0][7:0]  = 8'hfb;
    wv[0][15:8] = 8'd5;
    av[0] = bcast(8'd3);
    run_mac(1, 1, 0);
    check("t3_relu_mac", last_out, {112'd0, 8'd15, 8'd0});

    // 4: streaming RELU under toggling backpressure.
    rv[0] = bcast(8'hff); rv[1] = bcast(8'd7); rv[2] = bcast(8'h80);
    rv[3] = bcast(8'd0);  rv[4] = bcast(8'd127);
    rdy_mode = 2;
    c0 = out_cnt;
    run_relu(5);
    check("t4_beats", DW'(out_cnt - c0), DW'(5));
    check("t4_final", last_out, {L{8'h7f}});
    rdy_mode = 0;

    // 5: illegal op code and zero length are rejected.
    e0 = err_seen;
    start_op(7, 3, 0);
    @(negedge clk);
    check("t5_busy_op", DW'(busy), DW'(0));
    check("t5_tready_op", DW'(s_rdy), DW'(0));
    @(posedge clk); #1;
    start_op(0, 0, 0);
    @(negedge clk);
    check("t5_busy_k0", DW'(busy), DW'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_err_count", DW'(err_seen - e0), DW'(2));

    // 6: reset mid-load, then a fresh run sees cleared accumulators.
    start_op(0, 10, 0);
    for (int p = 0; p < 4; p++) begin
      drive_beat(bcast(8'd9));
      drive_beat(bcast(8'd9));
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t6_busy", DW'(busy), DW'(0));
    check("t6_tvalid", DW'(m_vld), DW'(0));
    check("t6_done", DW'(done), DW'(0));
    check("t6_tready", DW'(s_rdy), DW'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wv[0] = bcast(8'd1);
    av[0] = bcast(8'd1);
    run_mac(0, 1, 0);
    check("t6_result", last_out, {L{8'd1}});

    // Randomised mix of all modes, shifts, lengths and sink behaviour.
    for (int it = 0; it < 40; it++) begin
      rdy_mode = $urandom_range(0, 2);
      op = $urandom_range(0, 2);
      k  = $urandom_range(1, 8);
      if ($urandom_range(0, 9) == 0) begin
        start_op($urandom_range(0, 1) == 0 ? $urandom_range(3, 255) : op, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
      end else if (op == 2) begin
        for (int p = 0; p < k; p++) rv[p] = {$urandom, $urandom, $urandom, $urandom};
        run_relu(k);
      end else begin
        for (int p = 0; p < k; p++) begin
          wv[p] = {$urandom, $urandom, $urandom, $urandom};
          av[p] = {$urandom, $urandom, $urandom, $urandom};
        end
        run_mac(op, k, $urandom_range(0, 15));
      end
    end

    @(posedge clk);
    #1;
    check("final_q_empty", DW'(exp_q.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
